data_cache_wb_param: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate L1 data cache between the core's MEM stage and the line-wide memory port.
- Generalises the fixed 4-line/128-bit data cache with configurable line size, set count and address width.
- Adds an explicit miss FSM with a stall output, registered read responses, byte-enable stores, and a flush that writes back dirty lines before invalidating.

---
 rtl/data_cache_wb_param_if.sv | 40 ++++
 rtl/data_cache_wb_param.sv | 236 +++++++++++++++++++++++
 tb/tb_data_cache_wb_param.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_wb_param_if.sv
// CPU-side and line-memory-side signal bundle for data_cache_wb_param.
// master = the cache, slave = the core/memory environment driving it.
interface data_cache_wb_param_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16
);
    localparam int unsigned OFF_W = $clog2(LINE_BYTES);

    logic                      cpu_rd;
    logic                      cpu_wr;
    logic [ADDR_W-1:0]         cpu_addr;
    logic [31:0]               cpu_wdata;
    logic [3:0]                cpu_be;
    logic [31:0]               cpu_rdata;
    logic                      cpu_rvalid;
    logic                      cpu_stall;
    logic                      flush;
    logic                      flush_done;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_W-OFF_W-1:0]   mem_addr;
    logic [8*LINE_BYTES-1:0]   mem_wdata;
    logic [8*LINE_BYTES-1:0]   mem_rdata;
    logic                      mem_rvalid;
    logic                      mem_wack;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_be, flush,
        input  mem_rdata, mem_rvalid, mem_wack,
        output cpu_rdata, cpu_rvalid, cpu_stall, flush_done,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_be, flush,
        output mem_rdata, mem_rvalid, mem_wack,
        input  cpu_rdata, cpu_rvalid, cpu_stall, flush_done,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache_wb_param.sv
// Direct-mapped write-back/write-allocate L1 data cache with miss FSM and flush.
// Optional DATA_CACHE_PERF_EN adds saturating hit/miss/writeback counters.
module data_cache_wb_param #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned NUM_SETS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    data_cache_wb_param_if.master bus
`ifdef DATA_CACHE_PERF_EN
    ,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses,
    output logic [31:0]           perf_wbacks
`endif
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WORDS  = LINE_BYTES / 4;
    localparam int unsigned WS_W   = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int unsigned LINE_W = 8 * LINE_BYTES;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        StIdle, StWb, StFill, StResp, StFlScan, StFlWb, StFlDone
    } state_e;

    state_e            state_q;
    logic [31:0]       data_q [NUM_SETS][WORDS];
    logic [TAG_W-1:0]  tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q, dirty_q;
    logic [IDX_W-1:0]  scan_q;

    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [WS_W-1:0]   req_ws_q;
    logic              req_rd_q;
    logic [31:0]       req_wdata_q;
    logic [3:0]        req_be_q;

    logic [31:0]       rdata_q;
    logic              rvalid_q, flush_done_q, mem_req_q, mem_we_q;
    logic [TAG_W+IDX_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic [IDX_W-1:0]  cur_idx, wb_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [WS_W-1:0]   cur_ws;
    logic              hit, cpu_req;
    logic [LINE_W-1:0] wb_line;
    logic              unused_addr;

    assign cur_idx     = bus.cpu_addr[OFF_W+IDX_W-1:OFF_W];
    assign cur_tag     = bus.cpu_addr[ADDR_W-1:OFF_W+IDX_W];
    assign unused_addr = ^bus.cpu_addr[1:0];

    if (OFF_W > 2) begin : g_ws
        assign cur_ws = bus.cpu_addr[OFF_W-1:2];
    end else begin : g_ws_single
        assign cur_ws = '0;
    end

    assign cpu_req = bus.cpu_rd || bus.cpu_wr;
    assign hit     = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // The held request completes in StResp, so the core is released there.
    assign bus.cpu_stall = (state_q == StIdle) ? (bus.flush || (cpu_req && !hit))
                                               : (state_q != StResp);

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
        end
        return m;
    endfunction

    always_comb begin
        wb_idx  = (state_q == StFlScan) ? scan_q : cur_idx;
        wb_line = '0;
        for (int w = 0; w < WORDS; w++) wb_line[w*32 +: 32] = data_q[wb_idx][w];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            dirty_q      <= '0;
            scan_q       <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_ws_q     <= '0;
            req_rd_q     <= 1'b0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
        end else begin
            rvalid_q     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.flush) begin
                        state_q <= StFlScan;
                        scan_q  <= '0;
                    end else if (cpu_req && hit) begin
                        if (bus.cpu_rd) begin
                            rdata_q  <= data_q[cur_idx][cur_ws];
                            rvalid_q <= 1'b1;
                        end else if (bus.cpu_be != 4'b0) begin
                            data_q[cur_idx][cur_ws] <= merge(data_q[cur_idx][cur_ws],
                                                             bus.cpu_wdata, bus.cpu_be);
                            dirty_q[cur_idx] <= 1'b1;
                        end
                    end else if (cpu_req) begin
                        req_tag_q   <= cur_tag;
                        req_idx_q   <= cur_idx;
                        req_ws_q    <= cur_ws;
                        req_rd_q    <= bus.cpu_rd;
                        req_wdata_q <= bus.cpu_wdata;
                        req_be_q    <= bus.cpu_be;
                        mem_req_q   <= 1'b1;
                        if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                            state_q     <= StWb;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[cur_idx], cur_idx};
                            mem_wdata_q <= wb_line;
                        end else begin
                            state_q    <= StFill;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {cur_tag, cur_idx};
                        end
                    end
                end
                StWb: begin
                    if (bus.mem_wack) begin
                        dirty_q[req_idx_q] <= 1'b0;
                        mem_we_q           <= 1'b0;
                        mem_addr_q         <= {req_tag_q, req_idx_q};
                        state_q            <= StFill;
                    end
                end
                StFill: begin
                    if (bus.mem_rvalid) begin
                        for (int w = 0; w < WORDS; w++) begin
                            data_q[req_idx_q][w] <= bus.mem_rdata[w*32 +: 32];
                        end
                        tag_q[req_idx_q]   <= req_tag_q;
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= 1'b0;
                        mem_req_q          <= 1'b0;
                        state_q            <= StResp;
                    end
                end
                StResp: begin
                    if (req_rd_q) begin
                        rdata_q  <= data_q[req_idx_q][req_ws_q];
                        rvalid_q <= 1'b1;
                    end else if (req_be_q != 4'b0) begin
                        data_q[req_idx_q][req_ws_q] <= merge(data_q[req_idx_q][req_ws_q],
                                                             req_wdata_q, req_be_q);
                        dirty_q[req_idx_q] <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                StFlScan: begin
                    if (valid_q[scan_q] && dirty_q[scan_q]) begin
                        state_q     <= StFlWb;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[scan_q], scan_q};
                        mem_wdata_q <= wb_line;
                    end else if (scan_q == LastIdx) begin
                        state_q <= StFlDone;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                StFlWb: begin
                    if (bus.mem_wack) begin
                        dirty_q[scan_q] <= 1'b0;
                        mem_req_q       <= 1'b0;
                        if (scan_q == LastIdx) begin
                            state_q <= StFlDone;
                        end else begin
                            scan_q  <= scan_q + 1'b1;
                            state_q <= StFlScan;
                        end
                    end
                end
                StFlDone: begin
                    valid_q      <= '0;
                    flush_done_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DATA_CACHE_PERF_EN
    logic ev_hit, ev_miss, ev_wback;
    assign ev_hit   = (state_q == StIdle) && !bus.flush && cpu_req && hit;
    assign ev_miss  = (state_q == StIdle) && !bus.flush && cpu_req && !hit;
    assign ev_wback = ((state_q == StWb) || (state_q == StFlWb)) && bus.mem_wack;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbacks <= '0;
        end else begin
            if (ev_hit && (perf_hits != '1))     perf_hits   <= perf_hits + 1'b1;
            if (ev_miss && (perf_misses != '1))  perf_misses <= perf_misses + 1'b1;
            if (ev_wback && (perf_wbacks != '1)) perf_wbacks <= perf_wbacks + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_cache_wb_param.sv
// Scoreboard bench for data_cache_wb_param: load/memory expectations are queued by
// the stimulus and checked by separate monitor and memory-responder processes.
module tb_data_cache_wb_param;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned NUM_SETS   = 4;
    localparam int unsigned MA_W       = ADDR_W - 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    typedef struct {
        logic            we;
        logic [MA_W-1:0] addr;
        int              w;
        logic [31:0]     word;
    } mem_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fdone = 0;
    bit   mem_auto = 1'b1;

    rd_exp_t  rd_q [$];
    mem_exp_t mem_q [$];
    logic [127:0] mem_lines [int];

    data_cache_wb_param_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) bus ();

`ifdef DATA_CACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses, perf_wbacks;
`endif

    data_cache_wb_param #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .NUM_SETS(NUM_SETS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef DATA_CACHE_PERF_EN
        ,
        .perf_hits(perf_hits),
        .perf_misses(perf_misses),
        .perf_wbacks(perf_wbacks)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic exp_mem(input logic we, input int addr, input int w, input logic [31:0] word);
        mem_exp_t m;
        m.we = we; m.addr = MA_W'(addr); m.w = w; m.word = word;
        mem_q.push_back(m);
    endtask

    // Drives one request, waits until accepted (stall low), returns the stall count.
    task automatic acc(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp, output int stalls);
        rd_exp_t e;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr;
        bus.cpu_wdata = wdata; bus.cpu_be = be;
        stalls = 0;
        @(negedge clk);
        while (bus.cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.cpu_stall) begin
            check("accept_timeout", 1, 0);
        end else if (rd) begin
            e.data = exp; e.cyc = cyc + 1;
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_be = 4'b0;
    endtask

    initial begin : monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rvalid", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rdata", bus.cpu_rdata, e.data);
                    check("rvalid_cycle", cyc, e.cyc);
                end
            end
            if (bus.flush_done) n_fdone++;
        end
    end

    initial begin : mem_model
        mem_exp_t m;
        int a;
        bus.mem_rvalid = 1'b0; bus.mem_wack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_auto && bus.mem_req) begin
                a = int'(bus.mem_addr);
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", {32'(bus.mem_we), 32'(a)}, 64'hFFFF);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", bus.mem_we, m.we);
                    check("mem_addr", bus.mem_addr, m.addr);
                    if (m.w >= 0) check("wb_word", bus.mem_wdata[m.w*32 +: 32], m.word);
                end
                repeat (2) @(negedge clk);
                if (bus.mem_we) begin
                    mem_lines[a] = bus.mem_wdata;
                    bus.mem_wack = 1'b1;
                end else begin
                    bus.mem_rdata  = mem_lines.exists(a) ? mem_lines[a] : '0;
                    bus.mem_rvalid = 1'b1;
                end
                @(negedge clk);
                bus.mem_wack = 1'b0; bus.mem_rvalid = 1'b0;
            end
        end
    end

    initial begin : stim
        int st;
        int budget;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_be = '0; bus.flush = 1'b0;
        mem_lines[4]     = {32'h33333333, 32'h0BADF00D, 32'hDEADBEEF, 32'hA0A0A0A0};
        mem_lines['h14]  = {32'h14000003, 32'h14000002, 32'h14000001, 32'h14000000};
        mem_lines[1]     = {32'h01000003, 32'h01000002, 32'h01000001, 32'h01000000};
        mem_lines[2]     = {32'h02000003, 32'h02000002, 32'h02000001, 32'h02000000};
        mem_lines[3]     = {32'h03000003, 32'h03000002, 32'h03000001, 32'h03000000};
        mem_lines[5]     = {32'h05000003, 32'h05000002, 32'h05000001, 32'h05000000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rvalid", bus.cpu_rvalid, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_flush_done", bus.flush_done, 0);
        @(posedge clk); #1;

        // Cold miss, then hits on the filled line.
        exp_mem(0, 4, -1, 0);
        acc(1, 0, 32'h40, 0, 0, 32'hA0A0A0A0, st);
        check("cold_stalls", st > 0, 1);
        acc(1, 0, 32'h44, 0, 0, 32'hDEADBEEF, st);
        check("hit44_stalls", st, 0);
        acc(1, 0, 32'h48, 0, 0, 32'h0BADF00D, st);
        check("hit48_stalls", st, 0);

        // Partial store hit, read back merged word.
        acc(0, 1, 32'h44, 32'h11223344, 4'b0011, 0, st);
        check("store_hit_stalls", st, 0);
        acc(1, 0, 32'h44, 0, 0, 32'hDEAD3344, st);

        // Conflict miss with dirty victim: writeback then fill.
        exp_mem(1, 4, 1, 32'hDEAD3344);
        exp_mem(0, 'h14, -1, 0);
        acc(1, 0, 32'h144, 0, 0, 32'h14000001, st);
        check("conflict_stalls", st > 0, 1);
        exp_mem(0, 4, -1, 0);
        acc(1, 0, 32'h44, 0, 0, 32'hDEAD3344, st);

        // Simultaneous rd/wr: read wins, write is dropped.
        acc(1, 1, 32'h48, 32'hFFFFFFFF, 4'hF, 32'h0BADF00D, st);
        acc(1, 0, 32'h48, 0, 0, 32'h0BADF00D, st);

        // be=0 store is a no-op and leaves the line clean.
        exp_mem(0, 2, -1, 0);
        acc(1, 0, 32'h20, 0, 0, 32'h02000000, st);
        acc(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, st);
        acc(1, 0, 32'h20, 0, 0, 32'h02000000, st);

        // Store misses dirty sets 1 and 3.
        exp_mem(0, 1, -1, 0);
        acc(0, 1, 32'h10, 32'hCAFEF00D, 4'hF, 0, st);
        exp_mem(0, 3, -1, 0);
        acc(0, 1, 32'h34, 32'h12345678, 4'b1100, 0, st);
        acc(1, 0, 32'h34, 0, 0, 32'h12340001, st);

        // Flush: exactly two writebacks, in index order.
        exp_mem(1, 1, 0, 32'hCAFEF00D);
        exp_mem(1, 3, 1, 32'h12340001);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        budget = 0;
        while (n_fdone == 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        repeat (5) @(negedge clk);
        check("flush_done_count", n_fdone, 1);
        check("flush_mem_q_empty", mem_q.size(), 0);
        @(posedge clk); #1;
        exp_mem(0, 4, -1, 0);
        acc(1, 0, 32'h44, 0, 0, 32'hDEAD3344, st);
        check("post_flush_miss", st > 0, 1);

        // Reset while a fill is outstanding.
        mem_auto = 1'b0;
        bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h50;
        budget = 0;
        @(negedge clk);
        while (!bus.mem_req && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("rst_fill_req", bus.mem_req, 1);
        check("rst_fill_we", bus.mem_we, 0);
        check("rst_fill_addr", bus.mem_addr, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.cpu_rd = 1'b0;
        check("rst_drops_req", bus.mem_req, 0);
        @(negedge clk);
        bus.mem_rdata = mem_lines[5]; bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rvalid_ignored", bus.mem_req, 0);
        mem_auto = 1'b1;
        @(posedge clk); #1;
        exp_mem(0, 4, -1, 0);
        acc(1, 0, 32'h44, 0, 0, 32'hDEAD3344, st);
        check("empty_after_rst", st > 0, 1);
        exp_mem(0, 5, -1, 0);
        acc(1, 0, 32'h50, 0, 0, 32'h05000000, st);
        check("empty_after_rst_50", st > 0, 1);

        repeat (6) @(negedge clk);
        check("rd_q_empty", rd_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
